// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadows EX/MEM destination records and drives forwarding,
// load-use stalls, bubbles, branch flushes and freeze. Optional macro: HAZARD_FWD_EN (forwarding).
module hazard_ctrl #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [1:0]       hazard_optype,
    input  logic             rs1use,
    input  logic             rs2use,
    input  logic [RA_W-1:0]  rs1_addr,
    input  logic [RA_W-1:0]  rs2_addr,
    input  logic [RA_W-1:0]  rd_addr,
    input  logic             Branch,
    input  logic             mem_stall,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic             freeze,
    output logic [1:0]       forward_rs1,
    output logic [1:0]       forward_rs2,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_ALU  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;

    // The regfile writes before it reads, so nothing past MEM affects any output
    // and the WB record is not kept.
    logic [1:0]      ex_type_p0;
    logic [RA_W-1:0] ex_rd_p0;
    logic [1:0]      mem_type_p1;
    logic [RA_W-1:0] mem_rd_p1;

    logic rs1_hit_ex, rs2_hit_ex, rs1_hit_mem, rs2_hit_mem;
    logic hazard, dep_stall;

    function automatic logic is_writer(input logic [1:0] t, input logic [RA_W-1:0] rd);
        return ((t == OP_ALU) || (t == OP_LOAD)) && (rd != '0);
    endfunction

`ifdef HAZARD_FWD_EN
    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_EX_ALU  = 2'b01;
    localparam logic [1:0] FWD_MEM_ALU = 2'b10;
    localparam logic [1:0] FWD_MEM_LD  = 2'b11;

    function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic [1:0] ex_t,
                                           input logic hit_mem, input logic [1:0] mem_t);
        if (hit_ex && ex_t == OP_ALU)         return FWD_EX_ALU;
        else if (hit_mem && mem_t == OP_ALU)  return FWD_MEM_ALU;
        else if (hit_mem && mem_t == OP_LOAD) return FWD_MEM_LD;
        else                                  return FWD_RF;
    endfunction
`endif

    always_comb begin
        rs1_hit_ex  = rs1use && (rs1_addr == ex_rd_p0)  && is_writer(ex_type_p0, ex_rd_p0);
        rs2_hit_ex  = rs2use && (rs2_addr == ex_rd_p0)  && is_writer(ex_type_p0, ex_rd_p0);
        rs1_hit_mem = rs1use && (rs1_addr == mem_rd_p1) && is_writer(mem_type_p1, mem_rd_p1);
        rs2_hit_mem = rs2use && (rs2_addr == mem_rd_p1) && is_writer(mem_type_p1, mem_rd_p1);
`ifdef HAZARD_FWD_EN
        hazard = (rs1_hit_ex || rs2_hit_ex) && (ex_type_p0 == OP_LOAD);
`else
        // Without bypass paths every dependency on EX or MEM must wait for WB.
        hazard = rs1_hit_ex || rs2_hit_ex || rs1_hit_mem || rs2_hit_mem;
`endif
        dep_stall = id_valid && hazard;
    end

    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        freeze      = 1'b0;
        forward_rs1 = 2'b00;
        forward_rs2 = 2'b00;
        if (!rst) begin
            freeze = mem_stall;
            if (mem_stall) begin
                stall_pc   = 1'b1;
                stall_ifid = 1'b1;
            end else begin
                stall_pc    = dep_stall;
                stall_ifid  = dep_stall;
                bubble_idex = dep_stall;
                // A branch under stall has stale operands; it is resolved on the retry.
                flush_ifid  = id_valid && Branch && !dep_stall;
            end
`ifdef HAZARD_FWD_EN
            forward_rs1 = fwd_sel(rs1_hit_ex, ex_type_p0, rs1_hit_mem, mem_type_p1);
            forward_rs2 = fwd_sel(rs2_hit_ex, ex_type_p0, rs2_hit_mem, mem_type_p1);
`endif
        end
    end

    // ID -> EX (p0) -> MEM (p1) slot advance and performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_type_p0  <= OP_NONE;
            ex_rd_p0    <= '0;
            mem_type_p1 <= OP_NONE;
            mem_rd_p1   <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!freeze) begin
                mem_type_p1 <= ex_type_p0;
                mem_rd_p1   <= ex_rd_p0;
                if (id_valid && !bubble_idex) begin
                    ex_type_p0 <= hazard_optype;
                    ex_rd_p0   <= rd_addr;
                end else begin
                    ex_type_p0 <= OP_NONE;
                    ex_rd_p0   <= '0;
                end
            end
            if (stall_pc)   stall_count <= stall_count + CNT_W'(1);
            if (flush_ifid) flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule
